ipv4_checksum_sequencer: RTL
============================

# ipv4_checksum_sequencer

Snooping controller that computes the IPv4 header checksum of each packet passing the router output-port-lookup stream. It time-shares a single 16-bit ones'-complement adder across the nine header words and presents one result per packet on a valid/ready interface. It sits beside the lookup datapath: it observes the AXI-Stream handshake and never stalls the stream. Packets that arrive while a result is pending, and runt packets, are counted, not processed.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 256: snooped stream width. Only 256 is supported.
- CNT_WIDTH, 32: width of the drop and runt counters.

Ports:
- AXI_ACLK  in  1  sole clock; all logic is rising-edge.
- AXI_RESET  in  1  asynchronous, active-high reset.
- S_AXIS_TDATA  in  256  snooped beat data.
- S_AXIS_TVALID  in  1  snooped.
- S_AXIS_TREADY  in  1  snooped. A beat is accepted when TVALID & TREADY.
- S_AXIS_TLAST  in  1  snooped end of packet.
- cfg_enable  in  1  when 0, new packets are ignored; any in-flight computation still completes.
- chk_result  out  16  computed checksum (~folded sum).
- chk_rx  out  16  checksum field carried in the packet.
- chk_ok  out  1  chk_result == chk_rx.
- chk_valid  out  1  result available.
- chk_ready  in  1  consumer accepts the result.
- busy  out  1  state != IDLE.
- drop_count  out  CNT_WIDTH  start-of-packet beats (SOPs) skipped because the block was busy. Saturating.
- runt_count  out  CNT_WIDTH  single-beat packets. Saturating.

## Operation
- SOP tracking: SOP is the first accepted beat after reset or after an accepted beat with TLAST.
- The in-packet flag is maintained in every state, independent of the FSM.
- Header words in the SOP beat (16-bit each):
  - W0 = [143:128], W1 = [127:112], W2 = [111:96], W3 = [95:80], W4 = [79:64]
  - checksum field = [63:48], captured as chk_rx and excluded from the sum
  - W5 = [47:32], W6 = [31:16], W7 = [15:0]
- W8 = bits [255:240] of the second accepted beat.
- States:
  - IDLE: on an SOP with cfg_enable=1:
    - if TLAST is also set: runt_count++, stay in IDLE;
    - otherwise capture W0..W7 and chk_rx, clear acc, idx=0, go to ACCUM.
  - ACCUM: acc = fold(acc + W[idx]), idx++. After idx 7 is added:
    - go to WAIT_B1 if W8 is not yet captured;
    - otherwise go directly to ADD8.
  - WAIT_B1: hold until the second beat is captured, then go to ADD8.
  - ADD8: acc = fold(acc + W8), go to FINISH.
  - FINISH: chk_result = ~acc, compute chk_ok, go to DONE.
  - DONE: chk_valid=1. When chk_ready=1, return to IDLE.
- W8 is captured on the second accepted beat of a tracked packet in any non-IDLE state.
- fold(x): 17-bit sum; the result is x[15:0] + x[16] (end-around carry), computed in the same cycle.
- An SOP seen in any state other than IDLE increments drop_count. That packet produces no result.
- A packet that ends before its second beat never reaches ACCUM; it is counted as a runt.
- Outputs are stable while chk_valid=1 and are held after the handshake until the next FINISH.

## Timing
- Reset values: all outputs 0, state IDLE, in-packet flag clear, counters 0.
- Reset is asynchronous and may assert mid-packet or mid-computation:
  - the FSM returns to IDLE;
  - the next accepted beat after release is treated as an SOP.
- Latency: with the SOP accepted at cycle 0 and the second beat at cycle ≤ 8:
  - ACCUM runs cycles 1–8, ADD8 cycle 9, FINISH cycle 10;
  - chk_valid rises at cycle 11.
- A later second beat delays ADD8 to the cycle after that beat's capture.
- Minimum IDLE-to-IDLE time is 12 cycles with chk_ready held at 1. chk_valid drops the cycle after the handshake.
- Back-to-back packets shorter than 12 cycles therefore drop SOPs. This is intentional.
- SOP arriving in the cycle DONE hands off (chk_valid & chk_ready): counted as a drop, because the state is not IDLE.
- chk_valid does not depend combinationally on chk_ready.
- Counters stick at all-ones.

## Test plan
- Header 4500 0073 0000 4000 4011 [b861] c0a8 0001 c0a8, with 00c7 in the second beat; second beat at cycle 1; chk_ready=1 → chk_valid at cycle 11, chk_result=0xB861, chk_rx=0xB861, chk_ok=1, back to IDLE at cycle 12.
- Same header with the checksum field 0x0000 and the second beat delayed to cycle 15 → chk_result=0xB861, chk_ok=0, chk_valid at cycle 18.
- chk_ready held at 0 for 20 cycles while three further packets arrive → drop_count=3, outputs stable throughout, a single result handed off.
- Single-beat packet (TLAST on the SOP beat) → runt_count=1, busy stays 0, no chk_valid.
- All nine words = 0xFFFF with the checksum field 0xFFFF → acc=0xFFFF, chk_result=0x0000, chk_ok=0.
- AXI_RESET pulsed during ACCUM → all outputs 0 immediately; the following packet computes correctly. cfg_enable=0 during an SOP → no counters change and no result is produced.

Source files
------------

// File: rtl/ipv4_checksum_sequencer.sv
// ipv4_checksum_sequencer
//
// Watches the AXI-Stream handshake on the router output-port-lookup path and
// computes the IPv4 header checksum of each packet. It never drives the
// stream. A single 16-bit ones'-complement adder is shared across the nine
// header words. The block presents one result per packet on a valid/ready
// interface.
//
// Ports:
//   AXI_ACLK       clock, rising edge
//   AXI_RESET      asynchronous active-high reset
//   S_AXIS_TDATA   snooped beat data (256 bits)
//   S_AXIS_TVALID  snooped valid
//   S_AXIS_TREADY  snooped ready; a beat is accepted on TVALID & TREADY
//   S_AXIS_TLAST   snooped end-of-packet
//   cfg_enable     0 = ignore new packets (in-flight work still completes)
//   chk_result     computed checksum (~folded sum)
//   chk_rx         checksum field carried by the packet
//   chk_ok         chk_result == chk_rx
//   chk_valid      result available
//   chk_ready      consumer accepts the result
//   busy           FSM is not idle
//   drop_count     SOPs skipped while busy (saturating)
//   runt_count     single-beat packets seen while idle and enabled (saturating)
module ipv4_checksum_sequencer #(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int CNT_WIDTH           = 32
) (
    input  logic                           AXI_ACLK,
    input  logic                           AXI_RESET,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                           S_AXIS_TVALID,
    input  logic                           S_AXIS_TREADY,
    input  logic                           S_AXIS_TLAST,
    input  logic                           cfg_enable,
    output logic [15:0]                    chk_result,
    output logic [15:0]                    chk_rx,
    output logic                           chk_ok,
    output logic                           chk_valid,
    input  logic                           chk_ready,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           drop_count,
    output logic [CNT_WIDTH-1:0]           runt_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ACCUM   = 3'd1;
    localparam logic [2:0] WAIT_B1 = 3'd2;
    localparam logic [2:0] ADD8    = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]             state_q, state_d;
    logic                   inPkt_q, inPkt_d;
    logic [0:7][15:0]       hdrWords_q, hdrWords_d;
    logic [15:0]            rxCap_q, rxCap_d;
    logic [15:0]            acc_q, acc_d;
    logic [2:0]             idx_q, idx_d;
    logic [15:0]            w8_q, w8_d;
    logic                   w8Valid_q, w8Valid_d;
    logic                   secondPending_q, secondPending_d;
    logic [15:0]            result_q, result_d;
    logic [15:0]            rxOut_q, rxOut_d;
    logic                   ok_q, ok_d;
    logic [CNT_WIDTH-1:0]   drop_q, drop_d;
    logic [CNT_WIDTH-1:0]   runt_q, runt_d;

    logic beat;
    logic sop;
    logic w8Capture;
    logic w8Ready;
    logic unusedTdataBits;

    // Ones'-complement add: the end-around carry is folded back in the same
    // cycle. A second carry is impossible (max 0xFFFF + 0xFFFF = 0x1FFFE).
    function automatic logic [15:0] fold(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    assign beat = S_AXIS_TVALID & S_AXIS_TREADY;
    assign sop  = beat & ~inPkt_q;

    // The second beat of the tracked packet is captured only while busy. The
    // SOP itself is taken in IDLE, so the next accepted beat is always W8.
    assign w8Capture = (state_q != IDLE) & beat & ~sop & secondPending_q;

    // W8 may arrive in the same cycle the FSM needs it. Treating it as ready
    // then lets ADD8 follow immediately without a WAIT_B1 bubble.
    assign w8Ready = w8Valid_q | w8Capture;

    // Payload bits between the IP header and W8 are never examined.
    assign unusedTdataBits = ^S_AXIS_TDATA[239:144];

    // Next-state logic. The SOP tracker and the W8 capture run in every state,
    // independently of the FSM. Result registers change only in FINISH, so they
    // hold through DONE and until the next packet finishes.
    always_comb begin
        state_d         = state_q;
        inPkt_d         = inPkt_q;
        hdrWords_d      = hdrWords_q;
        rxCap_d         = rxCap_q;
        acc_d           = acc_q;
        idx_d           = idx_q;
        w8_d            = w8_q;
        w8Valid_d       = w8Valid_q;
        secondPending_d = secondPending_q;
        result_d        = result_q;
        rxOut_d         = rxOut_q;
        ok_d            = ok_q;
        drop_d          = drop_q;
        runt_d          = runt_q;

        if (beat) begin
            inPkt_d = ~S_AXIS_TLAST;
        end

        if (w8Capture) begin
            w8_d            = S_AXIS_TDATA[255:240];
            w8Valid_d       = 1'b1;
            secondPending_d = 1'b0;
        end

        if (sop && (state_q != IDLE) && (drop_q != '1)) begin
            drop_d = drop_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (sop && cfg_enable) begin
                    if (S_AXIS_TLAST) begin
                        if (runt_q != '1) begin
                            runt_d = runt_q + CNT_ONE;
                        end
                    end else begin
                        hdrWords_d      = {S_AXIS_TDATA[143:64], S_AXIS_TDATA[47:0]};
                        rxCap_d         = S_AXIS_TDATA[63:48];
                        acc_d           = 16'h0000;
                        idx_d           = 3'd0;
                        w8Valid_d       = 1'b0;
                        secondPending_d = 1'b1;
                        state_d         = ACCUM;
                    end
                end
            end
            ACCUM: begin
                acc_d = fold(acc_q, hdrWords_q[idx_q]);
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = w8Ready ? ADD8 : WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (w8Ready) begin
                    state_d = ADD8;
                end
            end
            ADD8: begin
                acc_d   = fold(acc_q, w8_q);
                state_d = FINISH;
            end
            FINISH: begin
                result_d = ~acc_q;
                rxOut_d  = rxCap_q;
                ok_d     = (~acc_q == rxCap_q);
                state_d  = DONE;
            end
            DONE: begin
                if (chk_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset may land mid-packet; clearing inPkt makes the
    // first accepted beat after release an SOP.
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state_q         <= IDLE;
            inPkt_q         <= 1'b0;
            hdrWords_q      <= '0;
            rxCap_q         <= 16'h0000;
            acc_q           <= 16'h0000;
            idx_q           <= 3'd0;
            w8_q            <= 16'h0000;
            w8Valid_q       <= 1'b0;
            secondPending_q <= 1'b0;
            result_q        <= 16'h0000;
            rxOut_q         <= 16'h0000;
            ok_q            <= 1'b0;
            drop_q          <= '0;
            runt_q          <= '0;
        end else begin
            state_q         <= state_d;
            inPkt_q         <= inPkt_d;
            hdrWords_q      <= hdrWords_d;
            rxCap_q         <= rxCap_d;
            acc_q           <= acc_d;
            idx_q           <= idx_d;
            w8_q            <= w8_d;
            w8Valid_q       <= w8Valid_d;
            secondPending_q <= secondPending_d;
            result_q        <= result_d;
            rxOut_q         <= rxOut_d;
            ok_q            <= ok_d;
            drop_q          <= drop_d;
            runt_q          <= runt_d;
        end
    end

    assign chk_result = result_q;
    assign chk_rx     = rxOut_q;
    assign chk_ok     = ok_q;
    assign chk_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign drop_count = drop_q;
    assign runt_count = runt_q;

endmodule
